// File: rtl/nfc_cal_sequencer.sv
// Command/address latch sequencer: turns handshaked CLE/ALE bytes into registered 4-phase
// NAND PHY output vectors (CE, WE, ALE, CLE, DQ) with setup, pulse and hold timing.
module nfc_cal_sequencer #(
  parameter int unsigned NumberOfWays = 4,
  parameter int unsigned WELowCycles  = 1,
  parameter int unsigned WEHighCycles = 1
) (
  input  logic                      iSystemClock,
  input  logic                      iModuleReset,
  input  logic [NumberOfWays-1:0]   iTargetID,
  input  logic                      iCmdValid,
  output logic                      oCmdReady,
  input  logic                      iCmdType,
  input  logic [7:0]                iCmdData,
  input  logic                      iCmdLast,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oPO_DQOutEnable,
  output logic [31:0]               oPO_DQ,
  output logic                      oPO_DQSOutEnable,
  output logic [7:0]                oPO_DQStrobe,
  output logic [2*NumberOfWays-1:0] oPO_ChipEnable,
  output logic [3:0]                oPO_ReadEnable,
  output logic [3:0]                oPO_WriteEnable,
  output logic [3:0]                oPO_AddressLatchEnable,
  output logic [3:0]                oPO_CommandLatchEnable
);

  typedef enum logic [2:0] {
    StIdle, StCeSetup, StWeLow, StWeHigh, StWaitNext, StCeHold
  } state_e;

  localparam logic [3:0] LowLoad  = 4'(WELowCycles - 1);
  localparam logic [3:0] HighLoad = 4'(WEHighCycles - 1);

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [7:0]                byte_q, byte_d;
  logic                      type_q, type_d;
  logic                      last_q, last_d;
  logic [NumberOfWays-1:0]   target_q, target_d;

  logic [2*NumberOfWays-1:0] ce_q, ce_d, ce_sel;
  logic [3:0]                we_q, we_d, ale_q, ale_d, cle_q, cle_d;
  logic                      dqoe_q, dqoe_d, done_q, done_d;
  logic [31:0]               dq_q, dq_d;
  logic                      accept;

  assign oCmdReady = ((state_q == StIdle) || (state_q == StWaitNext)) && !iModuleReset;
  assign oBusy     = (state_q != StIdle);
  assign accept    = iCmdValid && oCmdReady;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    type_d   = type_q;
    last_d   = last_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          byte_d   = iCmdData;
          type_d   = iCmdType;
          last_d   = iCmdLast;
          target_d = iTargetID;
          state_d  = StCeSetup;
        end
      end
      StCeSetup: begin
        state_d = StWeLow;
        cnt_d   = LowLoad;
      end
      StWeLow: begin
        if (cnt_q == 4'd0) begin
          state_d = StWeHigh;
          cnt_d   = HighLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWeHigh: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (last_q) begin
          // Second CE_HOLD cycle is the one that releases CE and raises done.
          state_d = StCeHold;
          cnt_d   = 4'd1;
        end else begin
          state_d = StWaitNext;
        end
      end
      StWaitNext: begin
        if (accept) begin
          byte_d  = iCmdData;
          type_d  = iCmdType;
          last_d  = iCmdLast;
          state_d = StWeLow;
          cnt_d   = LowLoad;
        end
      end
      StCeHold: begin
        if (cnt_q == 4'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ce_sel = '1;
    for (int k = 0; k < int'(NumberOfWays); k++) begin
      if (target_q[k]) ce_sel[2*k +: 2] = 2'b00;
    end
  end

  // PHY vectors are registered images of the current state, so they trail it by one cycle.
  always_comb begin
    ce_d   = ce_sel;
    we_d   = 4'hF;
    ale_d  = 4'h0;
    cle_d  = 4'h0;
    dqoe_d = 1'b0;
    dq_d   = dq_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: ce_d = '1;
      StWeLow, StWeHigh: begin
        we_d   = (state_q == StWeLow) ? 4'h0 : 4'hF;
        dqoe_d = 1'b1;
        dq_d   = {4{byte_q}};
        if (type_q) ale_d = 4'hF;
        else        cle_d = 4'hF;
      end
      StCeHold: begin
        if (cnt_q == 4'd0) begin
          ce_d   = '1;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iSystemClock) begin
    if (iModuleReset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      byte_q   <= 8'h00;
      type_q   <= 1'b0;
      last_q   <= 1'b0;
      target_q <= '0;
      ce_q     <= '1;
      we_q     <= 4'hF;
      ale_q    <= 4'h0;
      cle_q    <= 4'h0;
      dqoe_q   <= 1'b0;
      dq_q     <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      type_q   <= type_d;
      last_q   <= last_d;
      target_q <= target_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      ale_q    <= ale_d;
      cle_q    <= cle_d;
      dqoe_q   <= dqoe_d;
      dq_q     <= dq_d;
      done_q   <= done_d;
    end
  end

  assign oDone                  = done_q;
  assign oPO_DQOutEnable        = dqoe_q;
  assign oPO_DQ                 = dq_q;
  assign oPO_DQSOutEnable       = 1'b0;
  assign oPO_DQStrobe           = 8'hFF;
  assign oPO_ChipEnable         = ce_q;
  assign oPO_ReadEnable         = 4'hF;
  assign oPO_WriteEnable        = we_q;
  assign oPO_AddressLatchEnable = ale_q;
  assign oPO_CommandLatchEnable = cle_q;

endmodule

// File: tb/tb_nfc_cal_sequencer.sv
// Scoreboard bench: the driver queues expected byte pulses and completions, a negedge
// monitor measures each WE pulse and each oDone and compares against the queue.
module tb_nfc_cal_sequencer;
  localparam int L = 1;
  localparam int H = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, ctype, clast, rdy, busy, done, dqoe, dqsoe;
  logic [3:0]  tgt, re, we, ale, cle;
  logic [7:0]  cdata, strobe, ce;
  logic [31:0] dq;

  logic        v2, t2, l2, rdy2, busy2, done2, dqoe2, dqsoe2;
  logic [3:0]  g2, re2, we2, ale2, cle2;
  logic [7:0]  d2, strobe2, ce2;
  logic [31:0] dq2;

  nfc_cal_sequencer #(.NumberOfWays(4), .WELowCycles(L), .WEHighCycles(H)) dut (
    .iSystemClock(clk), .iModuleReset(rst), .iTargetID(tgt), .iCmdValid(valid),
    .oCmdReady(rdy), .iCmdType(ctype), .iCmdData(cdata), .iCmdLast(clast), .oBusy(busy),
    .oDone(done), .oPO_DQOutEnable(dqoe), .oPO_DQ(dq), .oPO_DQSOutEnable(dqsoe),
    .oPO_DQStrobe(strobe), .oPO_ChipEnable(ce), .oPO_ReadEnable(re), .oPO_WriteEnable(we),
    .oPO_AddressLatchEnable(ale), .oPO_CommandLatchEnable(cle)
  );

  nfc_cal_sequencer #(.NumberOfWays(4), .WELowCycles(3), .WEHighCycles(2)) dut2 (
    .iSystemClock(clk), .iModuleReset(rst), .iTargetID(g2), .iCmdValid(v2),
    .oCmdReady(rdy2), .iCmdType(t2), .iCmdData(d2), .iCmdLast(l2), .oBusy(busy2),
    .oDone(done2), .oPO_DQOutEnable(dqoe2), .oPO_DQ(dq2), .oPO_DQSOutEnable(dqsoe2),
    .oPO_DQStrobe(strobe2), .oPO_ChipEnable(ce2), .oPO_ReadEnable(re2),
    .oPO_WriteEnable(we2), .oPO_AddressLatchEnable(ale2), .oPO_CommandLatchEnable(cle2)
  );

  typedef struct {
    logic [31:0] dq;
    logic [3:0]  ale;
    logic [3:0]  cle;
    logic [7:0]  ce;
    int          low;
    int          hold;
  } byte_exp_t;

  typedef struct {
    int done_cyc;
    int ce_low;
    int nbytes;
  } done_exp_t;

  byte_exp_t bq[$];
  done_exp_t dqs[$];
  byte_exp_t cur, be;
  done_exp_t de;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit in_byte = 1'b0;
  int cur_low, cur_hold, bytes_seen, ce_low;
  logic       seq_t [16];
  logic [7:0] seq_d [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [3:0] t);
    logic [7:0] r;
    r = 8'hFF;
    for (int k = 0; k < 4; k++) if (t[k]) r[2*k +: 2] = 2'b00;
    return r;
  endfunction

  // Monitor: one byte record per WE pulse, one completion record per oDone.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ce != 8'hFF) ce_low++;
      if (in_byte) begin
        if (!dqoe) begin
          in_byte = 1'b0;
          chk("byte_expected", 64'(bq.size() != 0), 64'd1);
          if (bq.size() != 0) begin
            be = bq.pop_front();
            chk("byte_dq", 64'(cur.dq), 64'(be.dq));
            chk("byte_ale", 64'(cur.ale), 64'(be.ale));
            chk("byte_cle", 64'(cur.cle), 64'(be.cle));
            chk("byte_ce", 64'(cur.ce), 64'(be.ce));
            chk("byte_we_low_cycles", 64'(cur_low), 64'(be.low));
            chk("byte_hold_cycles", 64'(cur_hold), 64'(be.hold));
          end
        end else begin
          if (we == 4'h0) cur_low++;
          if (dq == cur.dq && ale == cur.ale && cle == cur.cle) cur_hold++;
        end
      end else if (we == 4'h0) begin
        in_byte  = 1'b1;
        bytes_seen++;
        cur_low  = 1;
        cur_hold = 1;
        cur.dq   = dq;
        cur.ale  = ale;
        cur.cle  = cle;
        cur.ce   = ce;
      end
      if (done) begin
        chk("done_expected", 64'(dqs.size() != 0), 64'd1);
        if (dqs.size() != 0) begin
          de = dqs.pop_front();
          chk("done_cycle", 64'(cyc), 64'(de.done_cyc));
          chk("done_ce_low_cycles", 64'(ce_low), 64'(de.ce_low));
          chk("done_byte_count", 64'(bytes_seen), 64'(de.nbytes));
          chk("done_busy", 64'(busy), 64'd0);
          chk("done_ce_released", 64'(ce), 64'hFF);
        end
        ce_low     = 0;
        bytes_seen = 0;
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_ce"}, 64'(ce), 64'hFF);
    chk({tag, "_we"}, 64'(we), 64'hF);
    chk({tag, "_re"}, 64'(re), 64'hF);
    chk({tag, "_ale"}, 64'(ale), 64'h0);
    chk({tag, "_cle"}, 64'(cle), 64'h0);
    chk({tag, "_dqoe"}, 64'(dqoe), 64'h0);
    chk({tag, "_dq"}, 64'(dq), 64'h0);
    chk({tag, "_dqsoe"}, 64'(dqsoe), 64'h0);
    chk({tag, "_dqs"}, 64'(strobe), 64'hFF);
    chk({tag, "_done"}, 64'(done), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic t, input logic [7:0] d, input logic l, input logic [3:0] g,
                      output int acc);
    int w;
    w = 0;
    valid = 1'b1; ctype = t; cdata = d; clast = l; tgt = g;
    while (!rdy && w < 100) begin
      @(negedge clk);
      w++;
    end
    acc = cyc + 1;
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: actual=not_ready required=ready");
    end
    @(negedge clk);
    valid = 1'b0; cdata = 8'h5A; ctype = ~t; clast = 1'b0; tgt = 4'b0110;
  endtask

  task automatic push_byte(input logic t, input logic [7:0] d, input logic [3:0] g);
    byte_exp_t e;
    e.dq   = {d, d, d, d};
    e.ale  = t ? 4'hF : 4'h0;
    e.cle  = t ? 4'h0 : 4'hF;
    e.ce   = pat(g);
    e.low  = L;
    e.hold = L + H;
    bq.push_back(e);
  endtask

  task automatic tx(input logic [3:0] g, input int n, input int fixed_total, input bit stall);
    int first, acc, bad, w;
    done_exp_t e;
    first = 0;
    for (int i = 0; i < n; i++) begin
      push_byte(seq_t[i], seq_d[i], g);
      send(seq_t[i], seq_d[i], (i == n - 1), g, acc);
      if (i == 0) first = acc;
      if (stall && i == 0) begin
        repeat (4) @(negedge clk);
        bad = 0;
        for (int s = 0; s < 10; s++) begin
          if (!(busy && rdy) || ce != pat(g) || we != 4'hF || dqoe) bad++;
          cdata = 8'(s * 17);
          @(negedge clk);
        end
        chk("stall_wait_next_cycles_bad", 64'(bad), 64'd0);
      end
    end
    e.done_cyc = (fixed_total > 0) ? first + fixed_total : acc + L + H + 2;
    e.ce_low   = (g == 4'b0000) ? 0 : e.done_cyc - first - 1;
    e.nbytes   = n;
    dqs.push_back(e);
    w = 0;
    while (dqs.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (dqs.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: actual=no_done required=done");
      dqs.delete();
      bq.delete();
    end
  endtask

  initial begin
    int acc, acc2, lowc, alec, donec, dcount;
    rst = 1'b1; valid = 1'b0; ctype = 1'b0; clast = 1'b0; cdata = 8'h00; tgt = 4'h0;
    v2 = 1'b0; t2 = 1'b0; l2 = 1'b0; d2 = 8'h00; g2 = 4'h0;
    ce_low = 0; bytes_seen = 0; cur_low = 0; cur_hold = 0;
    repeat (3) @(negedge clk);
    check_idle("rst_hold");
    chk("rst_hold_ready", 64'(rdy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_release");
    chk("idle_ready", 64'(rdy), 64'd1);
    mon_en = 1'b1;

    // Single command byte, way 0.
    seq_t[0] = 1'b0; seq_d[0] = 8'hFF;
    tx(4'b0001, 1, 5, 1'b0);

    // Read page on way 2 with valid held high.
    seq_t[0] = 1'b0; seq_d[0] = 8'h00;
    seq_t[1] = 1'b1; seq_d[1] = 8'h12;
    seq_t[2] = 1'b1; seq_d[2] = 8'h34;
    seq_t[3] = 1'b1; seq_d[3] = 8'h56;
    seq_t[4] = 1'b1; seq_d[4] = 8'h78;
    seq_t[5] = 1'b1; seq_d[5] = 8'h9A;
    seq_t[6] = 1'b0; seq_d[6] = 8'h30;
    tx(4'b0100, 7, 23, 1'b0);

    // Stall in WAIT_NEXT after the first byte, way 3.
    seq_t[0] = 1'b0; seq_d[0] = 8'h60;
    seq_t[1] = 1'b1; seq_d[1] = 8'h11;
    seq_t[2] = 1'b1; seq_d[2] = 8'h22;
    seq_t[3] = 1'b0; seq_d[3] = 8'hD0;
    tx(4'b1000, 4, 0, 1'b1);

    // No way selected, then broadcast.
    seq_t[0] = 1'b0; seq_d[0] = 8'h90;
    tx(4'b0000, 1, 5, 1'b0);
    seq_t[0] = 1'b1; seq_d[0] = 8'hC3;
    tx(4'b1111, 1, 5, 1'b0);

    // Reset while byte 3 is in its WE low phase.
    push_byte(1'b0, 8'h80, 4'b0001);
    send(1'b0, 8'h80, 1'b0, 4'b0001, acc);
    push_byte(1'b1, 8'h01, 4'b0001);
    send(1'b1, 8'h01, 1'b0, 4'b0001, acc);
    send(1'b1, 8'h02, 1'b0, 4'b0001, acc);
    #1;
    mon_en = 1'b0;
    chk("rst_prior_bytes_seen", 64'(bq.size()), 64'd0);
    @(negedge clk);
    chk("rst_byte3_we_low", 64'(we), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid");
    chk("rst_mid_ready", 64'(rdy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_mid_after");
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("rst_no_done", 64'(dcount), 64'd0);
    in_byte = 1'b0; ce_low = 0; bytes_seen = 0;
    bq.delete(); dqs.delete();
    mon_en = 1'b1;
    seq_t[0] = 1'b0; seq_d[0] = 8'h70;
    tx(4'b0010, 1, 5, 1'b0);

    // Stretched timing on the second instance: WE low 3, high 2.
    v2 = 1'b1; t2 = 1'b1; d2 = 8'hA5; l2 = 1'b1; g2 = 4'b0001;
    acc2 = cyc + 1;
    @(negedge clk);
    v2 = 1'b0; d2 = 8'h00; t2 = 1'b0;
    lowc = 0; alec = 0; donec = -1;
    for (int i = 0; i < 12; i++) begin
      if (we2 == 4'h0) lowc++;
      if (ale2 == 4'hF && dqoe2 && dq2 == 32'hA5A5A5A5 && cle2 == 4'h0) alec++;
      if (done2) donec = cyc - acc2;
      @(negedge clk);
    end
    chk("slow_we_low_cycles", 64'(lowc), 64'd3);
    chk("slow_ale_dq_hold_cycles", 64'(alec), 64'd5);
    chk("slow_done_latency", 64'(donec), 64'd8);

    repeat (3) @(negedge clk);
    chk("end_byte_queue_empty", 64'(bq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
